fighter_action_ctrl: RTL and testbench

//  Per-player action sequencer between the button inputs and the player movement datapath.

---
 rtl/fighter_pkg.sv | 26 ++
 rtl/frame_timer.sv | 27 ++
 rtl/fighter_action_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fighter_action_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// Action-state codes and default frame timings shared by the sequencer, sprite select and hit logic.
// Pure declarations; no latency or flow-control behaviour.
package fighter_pkg;
    localparam int ACT_W = 3;

    typedef enum logic [ACT_W-1:0] {
        ACT_IDLE     = 3'd0,
        ACT_WALK     = 3'd1,
        ACT_JUMP     = 3'd2,
        ACT_STARTUP  = 3'd3,
        ACT_ACTIVE   = 3'd4,
        ACT_RECOVERY = 3'd5,
        ACT_HITSTUN  = 3'd6,
        ACT_KO       = 3'd7
    } act_t;

    localparam int DEF_STARTUP_FRAMES  = 4;
    localparam int DEF_ACTIVE_FRAMES   = 3;
    localparam int DEF_RECOVERY_FRAMES = 8;
    localparam int DEF_HITSTUN_FRAMES  = 12;
    localparam int DEF_CNT_W           = 5;

    // Jump watchdog: longest a jump may wait for the mover to report airborne.
    localparam int JUMP_WD_FRAMES = 255;
    localparam int JUMP_WD_W      = 8;
endpackage

// File: rtl/frame_timer.sv
// Per-frame down-counter: loads on SCEN when asked, otherwise decrements to 0 and holds; done when 0.
// Latency: count visible 1 clk after the SCEN; no backpressure, moves only on SCEN.
module frame_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scen,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (scen) begin
            if (load) begin
                cnt <= load_val;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = (cnt == '0);
endmodule

// File: rtl/fighter_action_ctrl.sv
// Per-player action sequencer: walk/jump gating, attack phases, hitstun and KO lockout.
// Latency: outputs registered, 1 clk after the deciding SCEN; no backpressure, state moves only on SCEN.
// Optional attack buffering during RECOVERY when INPUT_BUFFER_EN is defined.
module fighter_action_ctrl
    import fighter_pkg::*;
#(
    parameter int STARTUP_FRAMES  = DEF_STARTUP_FRAMES,
    parameter int ACTIVE_FRAMES   = DEF_ACTIVE_FRAMES,
    parameter int RECOVERY_FRAMES = DEF_RECOVERY_FRAMES,
    parameter int HITSTUN_FRAMES  = DEF_HITSTUN_FRAMES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SCEN,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             btn_jump,
    input  logic             btn_attack,
    input  logic             jump_active,
    input  logic             hit_taken,
    input  logic             health_zero,
    output logic             move_enable,
    output logic             move_left,
    output logic             move_right,
    output logic             jump,
    output logic             hitbox_active,
    output logic [2:0]       action_state,
    output logic [CNT_W-1:0] frame_cnt
);
    act_t                 state, state_nxt;
    logic                 prev_jump, prev_atk;
    logic                 jump_rise, atk_rise;
    logic                 jump_seen, jump_seen_nxt;
    logic [JUMP_WD_W-1:0] jump_wd, jump_wd_nxt;
    logic                 left_nxt, right_nxt;
    logic                 tmr_load, tmr_done;
    logic [CNT_W-1:0]     tmr_val;
    logic                 recov_to_startup;

    assign jump_rise = btn_jump & ~prev_jump;
    assign atk_rise  = btn_attack & ~prev_atk;

`ifdef INPUT_BUFFER_EN
    logic buf_atk, buf_atk_nxt;

    // Any exit from RECOVERY (normal end, hitstun, KO) drops the buffered press.
    assign recov_to_startup = buf_atk | atk_rise;
    assign buf_atk_nxt      = (state_nxt == ACT_RECOVERY) &&
                              (buf_atk || (state == ACT_RECOVERY && atk_rise));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_atk <= 1'b0;
        end else if (SCEN) begin
            buf_atk <= buf_atk_nxt;
        end
    end
`else
    assign recov_to_startup = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (state == ACT_KO || health_zero) begin
            state_nxt = ACT_KO;
        end else if (hit_taken && state != ACT_HITSTUN) begin
            state_nxt = ACT_HITSTUN;
        end else begin
            case (state)
                ACT_IDLE, ACT_WALK: begin
                    if (!jump_active) begin
                        if (atk_rise)                   state_nxt = ACT_STARTUP;
                        else if (jump_rise)             state_nxt = ACT_JUMP;
                        else if (btn_left ^ btn_right)  state_nxt = ACT_WALK;
                        else                            state_nxt = ACT_IDLE;
                    end
                end
                ACT_JUMP: begin
                    if (!jump_active &&
                        (jump_seen || jump_wd == JUMP_WD_W'(JUMP_WD_FRAMES - 1)))
                        state_nxt = ACT_IDLE;
                end
                ACT_STARTUP:  if (tmr_done) state_nxt = ACT_ACTIVE;
                ACT_ACTIVE:   if (tmr_done) state_nxt = ACT_RECOVERY;
                ACT_RECOVERY: if (tmr_done) state_nxt = recov_to_startup ? ACT_STARTUP : ACT_IDLE;
                ACT_HITSTUN:  if (tmr_done) state_nxt = ACT_IDLE;
                default:      state_nxt = state;
            endcase
        end
    end

    always_comb begin
        tmr_load = (state_nxt != state);
        tmr_val  = '0;
        case (state_nxt)
            ACT_STARTUP:  tmr_val = CNT_W'(STARTUP_FRAMES - 1);
            ACT_ACTIVE:   tmr_val = CNT_W'(ACTIVE_FRAMES - 1);
            ACT_RECOVERY: tmr_val = CNT_W'(RECOVERY_FRAMES - 1);
            ACT_HITSTUN:  tmr_val = CNT_W'(HITSTUN_FRAMES - 1);
            default:      tmr_load = 1'b1;  // untimed states pin the count at 0
        endcase

        jump_seen_nxt = 1'b0;
        jump_wd_nxt   = '0;
        if (state == ACT_JUMP && state_nxt == ACT_JUMP) begin
            jump_seen_nxt = jump_seen | jump_active;
            jump_wd_nxt   = jump_seen ? jump_wd : jump_wd + 1'b1;
        end

        // Takeoff direction is latched on the entry frame and held for the whole jump.
        left_nxt  = 1'b0;
        right_nxt = 1'b0;
        case (state_nxt)
            ACT_WALK: begin
                left_nxt  = btn_left & ~btn_right;
                right_nxt = btn_right & ~btn_left;
            end
            ACT_JUMP: begin
                left_nxt  = (state == ACT_JUMP) ? move_left  : btn_left;
                right_nxt = (state == ACT_JUMP) ? move_right : btn_right;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ACT_IDLE;
            prev_jump     <= 1'b0;
            prev_atk      <= 1'b0;
            jump_seen     <= 1'b0;
            jump_wd       <= '0;
            move_enable   <= 1'b0;
            move_left     <= 1'b0;
            move_right    <= 1'b0;
            jump          <= 1'b0;
            hitbox_active <= 1'b0;
        end else if (SCEN) begin
            state         <= state_nxt;
            prev_jump     <= btn_jump;
            prev_atk      <= btn_attack;
            jump_seen     <= jump_seen_nxt;
            jump_wd       <= jump_wd_nxt;
            move_enable   <= (state_nxt == ACT_IDLE) || (state_nxt == ACT_WALK) ||
                             (state_nxt == ACT_JUMP);
            move_left     <= left_nxt;
            move_right    <= right_nxt;
            jump          <= (state_nxt == ACT_JUMP) && (state != ACT_JUMP);
            hitbox_active <= (state_nxt == ACT_ACTIVE);
        end
    end

    assign action_state = state;

    frame_timer #(.CNT_W(CNT_W)) u_frame_timer (
        .clk      (clk),
        .reset    (reset),
        .scen     (SCEN),
        .load     (tmr_load),
        .load_val (tmr_val),
        .cnt      (frame_cnt),
        .done     (tmr_done)
    );
endmodule

// File: tb/tb_fighter_action_ctrl.sv
// Scoreboard bench for fighter_action_ctrl: a frame-level reference model pushes expected outputs per SCEN,
// a monitor pops and compares after each SCEN edge and checks that outputs hold between ticks.
module tb_fighter_action_ctrl;
    localparam int T_STARTUP = 4, T_ACTIVE = 3, T_RECOVERY = 8, T_HITSTUN = 12, WD_FRAMES = 255;
`ifdef INPUT_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, scen = 1'b0;
    logic btn_left = 1'b0, btn_right = 1'b0, btn_jump = 1'b0, btn_attack = 1'b0;
    logic jump_active = 1'b0, hit_taken = 1'b0, health_zero = 1'b0;
    logic move_enable, move_left, move_right, jump, hitbox_active;
    logic [2:0]  action_state;
    logic [4:0]  frame_cnt;
    logic [12:0] dut_vec;

    int n_checks = 0, n_fail = 0;
    logic [12:0] exp_q[$];
    string       name_q[$];

    // Reference model state, in frames rather than counter codes.
    int m_st, m_rem, m_wd;
    bit m_seen, m_buf, m_pj, m_pa, m_ml, m_mr;

    assign dut_vec = {move_enable, move_left, move_right, jump, hitbox_active, action_state, frame_cnt};

    fighter_action_ctrl dut (
        .clk(clk), .reset(rst), .SCEN(scen),
        .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump), .btn_attack(btn_attack),
        .jump_active(jump_active), .hit_taken(hit_taken), .health_zero(health_zero),
        .move_enable(move_enable), .move_left(move_left), .move_right(move_right), .jump(jump),
        .hitbox_active(hitbox_active), .action_state(action_state), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_vec(string nm, logic [12:0] act, logic [12:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got me=%b l=%b r=%b j=%b hb=%b st=%0d fc=%0d expected me=%b l=%b r=%b j=%b hb=%b st=%0d fc=%0d",
                     nm, $time, act[12], act[11], act[10], act[9], act[8], act[7:5], act[4:0],
                     exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:5], exp[4:0]);
        end
    endtask

    function automatic int dur(int st);
        case (st)
            3: return T_STARTUP;
            4: return T_ACTIVE;
            5: return T_RECOVERY;
            6: return T_HITSTUN;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_st = 0; m_rem = 0; m_wd = 0;
        m_seen = 0; m_buf = 0; m_pj = 0; m_pa = 0; m_ml = 0; m_mr = 0;
    endtask

    task automatic model_step(output logic [12:0] e);
        bit ar, jr, jumped;
        int nxt;
        logic [2:0] st3;
        logic [4:0] fc5;
        ar  = btn_attack && !m_pa;
        jr  = btn_jump && !m_pj;
        nxt = m_st;
        if (m_st == 7 || health_zero) nxt = 7;
        else if (hit_taken && m_st != 6) nxt = 6;
        else if (m_st <= 1) begin
            if (!jump_active) nxt = ar ? 3 : jr ? 2 : (btn_left != btn_right) ? 1 : 0;
        end else if (m_st == 2) begin
            if (!jump_active && (m_seen || m_wd == WD_FRAMES)) nxt = 0;
        end else if (m_rem == 1) begin
            case (m_st)
                3: nxt = 4;
                4: nxt = 5;
                5: nxt = (BUF_EN && (m_buf || ar)) ? 3 : 0;
                default: nxt = 0;
            endcase
        end
        jumped = (nxt == 2) && (m_st != 2);
        if (nxt != m_st) begin
            m_rem = dur(nxt); m_wd = 1; m_seen = 0; m_buf = 0;
            if (nxt == 2) begin m_ml = btn_left; m_mr = btn_right; end
        end else begin
            if (m_rem > 0) m_rem--;
            m_wd++;
            if (m_st == 2 && jump_active) m_seen = 1;
            if (m_st == 5 && ar && BUF_EN) m_buf = 1;
        end
        if (nxt == 1) begin
            m_ml = btn_left && !btn_right;
            m_mr = btn_right && !btn_left;
        end else if (nxt != 2) begin
            m_ml = 0; m_mr = 0;
        end
        m_pa = btn_attack; m_pj = btn_jump; m_st = nxt;
        st3 = 3'(nxt);
        fc5 = (m_rem == 0) ? 5'd0 : 5'(m_rem - 1);
        e = {nxt <= 2, m_ml, m_mr, jumped, nxt == 4, st3, fc5};
    endtask

    // Called at posedge+2 with the frame's inputs already applied.
    task automatic tick(string nm);
        logic [12:0] e;
        model_step(e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        scen = 1'b1;
        @(posedge clk); #2;
        scen = 1'b0;
    endtask

    task automatic do_reset(string nm);
        @(negedge clk); #1;
        rst = 1'b1; #1;
        cmp_vec({nm, "_async"}, dut_vec, 13'd0);
        {btn_left, btn_right, btn_jump, btn_attack, jump_active, hit_taken, health_zero} = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk); #2;
        cmp_vec({nm, "_state"}, dut_vec, 13'd0);
    endtask

    // Monitor: pops one expectation per SCEN edge, otherwise outputs must hold.
    initial begin
        logic [12:0] last_exp;
        logic        se;
        string       nm;
        last_exp = '0;
        forever begin
            @(posedge clk);
            se = scen;
            @(negedge clk);
            if (rst) begin
                last_exp = '0;
            end else if (se) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_underflow", 1, 0);
                end else begin
                    last_exp = exp_q.pop_front();
                    nm = name_q.pop_front();
                    cmp_vec(nm, dut_vec, last_exp);
                end
            end else begin
                cmp_vec("hold", dut_vec, last_exp);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n_su, n_ac, n_re, n_hb, n_me, n_j, n_hs, g;
        logic [6:0] r_in;
        model_reset();
        do_reset("reset");

        // Idle after reset
        tick("t1_idle"); tick("t1_idle");
        chk("t1_state", action_state, 0);
        chk("t1_move_enable", move_enable, 1);
        chk("t1_cmds", {move_left, move_right, jump, hitbox_active}, 0);

        // Walking and conflicting directions
        btn_right = 1;
        repeat (3) tick("t2_walk");
        chk("t2_state", action_state, 1);
        chk("t2_right", move_right, 1);
        btn_left = 1;
        tick("t2_both");
        chk("t2_both_cmds", {move_left, move_right}, 0);
        btn_left = 0; btn_right = 0;
        tick("t2_release");

        // Full attack sequence
        btn_attack = 1;
        n_su = 0; n_ac = 0; n_re = 0; n_hb = 0; n_me = 0;
        for (int i = 0; i < 16; i++) begin
            tick("t3_attack");
            if (action_state == 3) n_su++;
            if (action_state == 4) n_ac++;
            if (action_state == 5) n_re++;
            n_hb += int'(hitbox_active);
            if (i < 15) n_me += int'(move_enable);
        end
        chk("t3_startup_frames", n_su, T_STARTUP);
        chk("t3_active_frames", n_ac, T_ACTIVE);
        chk("t3_recovery_frames", n_re, T_RECOVERY);
        chk("t3_hitbox_frames", n_hb, T_ACTIVE);
        chk("t3_move_enable_frames", n_me, 0);
        chk("t3_end_state", action_state, 0);
        btn_attack = 0;
        tick("t3_release");

        // Jump with takeoff direction and a 40-frame airborne period
        btn_left = 1; btn_jump = 1;
        tick("t4_takeoff");
        chk("t4_jump_pulse", jump, 1);
        chk("t4_takeoff_left", move_left, 1);
        n_j = int'(jump);
        btn_jump = 0; btn_left = 0;
        repeat (2) begin tick("t4_ground"); n_j += int'(jump); end
        jump_active = 1;
        repeat (40) begin tick("t4_air"); n_j += int'(jump); end
        chk("t4_air_state", action_state, 2);
        chk("t4_left_held", move_left, 1);
        jump_active = 0;
        tick("t4_land");
        chk("t4_landed", action_state, 0);
        chk("t4_jump_count", n_j, 1);

        // Hit on the 2nd active frame, hit_taken held through hitstun
        btn_attack = 1;
        tick("t5_attack");
        btn_attack = 0;
        repeat (5) tick("t5_windup");
        chk("t5_active2", hitbox_active, 1);
        hit_taken = 1;
        tick("t5_hit");
        chk("t5_hitbox_off", hitbox_active, 0);
        chk("t5_hitstun", action_state, 6);
        chk("t5_hitstun_cnt", frame_cnt, T_HITSTUN - 1);
        n_hs = 1;
        repeat (12) begin tick("t5_stun"); if (action_state == 6) n_hs++; end
        chk("t5_hitstun_frames", n_hs, T_HITSTUN);
        chk("t5_back_idle", action_state, 0);
        tick("t5_rearm");
        chk("t5_rearm_state", action_state, 6);
        hit_taken = 0;
        repeat (12) tick("t5_stun2");

        // KO is sticky
        btn_right = 1;
        tick("t5_walk");
        health_zero = 1;
        tick("t5_ko");
        chk("t5_ko_state", action_state, 7);
        health_zero = 0; btn_attack = 1; hit_taken = 1; btn_jump = 1;
        repeat (5) tick("t5_ko_hold");
        chk("t5_ko_sticky", action_state, 7);
        chk("t5_ko_frozen", move_enable, 0);
        do_reset("ko_reset");

        // Attack press in recovery frame 5
        btn_attack = 1;
        tick("t6_attack");
        btn_attack = 0;
        repeat (11) tick("t6_run");
        chk("t6_recov5_cnt", frame_cnt, T_RECOVERY - 5);
        btn_attack = 1;
        tick("t6_press");
        btn_attack = 0;
        repeat (2) tick("t6_recov");
        tick("t6_end");
        chk("t6_after_recovery", action_state, BUF_EN ? 3 : 0);
        repeat (16) tick("t6_drain");

        // Reset mid-attack
        btn_attack = 1;
        tick("t7_attack");
        repeat (4) tick("t7_run");
        chk("t7_pre_reset_hitbox", hitbox_active, 1);
        do_reset("t7_reset");

        // Jump watchdog when the mover never reports airborne
        btn_jump = 1;
        tick("wd_takeoff");
        btn_jump = 0;
        repeat (WD_FRAMES - 1) tick("wd_wait");
        chk("wd_still_jump", action_state, 2);
        tick("wd_exit");
        chk("wd_exit_idle", action_state, 0);

        // Randomized frames with noise between ticks
        r_in = '0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 400 == 399) begin
                do_reset("rand_reset");
                r_in = '0;
            end
            g = $urandom_range(0, 2);
            repeat (g) begin
                {btn_left, btn_right, btn_jump, btn_attack, jump_active, hit_taken, health_zero} = 7'($urandom);
                @(posedge clk); #2;
            end
            for (int b = 3; b < 7; b++) if ($urandom_range(0, 3) == 0) r_in[b] = ~r_in[b];
            if ($urandom_range(0, 5) == 0) r_in[2] = ~r_in[2];
            r_in[1] = ($urandom_range(0, 24) == 0);
            r_in[0] = ($urandom_range(0, 699) == 0);
            {btn_left, btn_right, btn_jump, btn_attack, jump_active, hit_taken, health_zero} = r_in;
            tick("rand");
        end

        @(negedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
